// File: rtl/vga_pixel_counter.sv
// VGA timing generator: pixel-rate divider, free-running h/v counters and derived strobes.
// Define VGA_FRAME_CNT_EN to build the 8-bit frame_count register; otherwise frame_count is tied to 0.
module vga_pixel_counter #(
  parameter int CLK_DIV   = 4,
  parameter int H_TOTAL   = 800,
  parameter int V_TOTAL   = 525,
  parameter int H_VISIBLE = 640,
  parameter int V_VISIBLE = 480
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  output logic       pixel_tick,
  output logic [9:0] h_counter,
  output logic [9:0] v_counter,
  output logic       display_en,
  output logic [9:0] x_pixel,
  output logic [9:0] y_pixel,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             line_end;
  logic             frame_end;

  assign pixel_tick = en && (div_cnt == DIV_LAST);
  assign line_end   = pixel_tick && (h_counter == H_LAST);
  assign frame_end  = line_end && (v_counter == V_LAST);

  // With CLK_DIV=1 DIV_LAST is 0, so div_cnt stays 0 and pixel_tick follows en.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (en) begin
      div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_counter <= '0;
      v_counter <= '0;
    end else if (pixel_tick) begin
      if (line_end) begin
        h_counter <= '0;
        v_counter <= (v_counter == V_LAST) ? '0 : v_counter + 10'd1;
      end else begin
        h_counter <= h_counter + 10'd1;
      end
    end
  end

`ifdef VGA_FRAME_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_count <= '0;
    end else if (frame_end) begin
      frame_count <= frame_count + 8'd1;
    end
  end
`else
  assign frame_count = '0;
`endif

  // 11-bit compares so a visible width of 1024 does not truncate to 0.
  assign display_en  = ({1'b0, h_counter} < 11'(H_VISIBLE)) &&
                       ({1'b0, v_counter} < 11'(V_VISIBLE));
  assign x_pixel     = display_en ? h_counter : '0;
  assign y_pixel     = display_en ? v_counter : '0;
  assign line_start  = pixel_tick && (h_counter == '0);
  assign frame_start = line_start && (v_counter == '0);

endmodule

// File: tb/tb_vga_pixel_counter.sv
// Bench for vga_pixel_counter: a default 640x480 instance and a small CLK_DIV=1 instance,
// each tracked every cycle by a reference model feeding an expectation queue, plus directed checks.
module tb_vga_pixel_counter;

`ifdef VGA_FRAME_CNT_EN
  localparam bit FC_EN = 1'b1;
`else
  localparam bit FC_EN = 1'b0;
`endif

  localparam int unsigned A_DIV = 4, A_HT = 800, A_VT = 525, A_HV = 640, A_VV = 480;
  localparam int unsigned B_DIV = 1, B_HT = 20,  B_VT = 8,   B_HV = 16,  B_VV = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_rst, a_en, a_tick, a_de, a_ls, a_fs;
  logic [9:0] a_h, a_v, a_x, a_y;
  logic [7:0] a_fc;
  logic       b_rst, b_en, b_tick, b_de, b_ls, b_fs;
  logic [9:0] b_h, b_v, b_x, b_y;
  logic [7:0] b_fc;

  vga_pixel_counter u_dut_a (
    .clk(clk), .reset(a_rst), .en(a_en), .pixel_tick(a_tick),
    .h_counter(a_h), .v_counter(a_v), .display_en(a_de),
    .x_pixel(a_x), .y_pixel(a_y), .line_start(a_ls),
    .frame_start(a_fs), .frame_count(a_fc)
  );

  vga_pixel_counter #(
    .CLK_DIV(1), .H_TOTAL(20), .V_TOTAL(8), .H_VISIBLE(16), .V_VISIBLE(6)
  ) u_dut_b (
    .clk(clk), .reset(b_rst), .en(b_en), .pixel_tick(b_tick),
    .h_counter(b_h), .v_counter(b_v), .display_en(b_de),
    .x_pixel(b_x), .y_pixel(b_y), .line_start(b_ls),
    .frame_start(b_fs), .frame_count(b_fc)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  typedef struct { int unsigned div, h, v, fc; } mstate_t;
  typedef struct {
    logic tick; int unsigned h, v; logic de; int unsigned x, y; logic ls, fs; int unsigned fc;
  } mout_t;

  function automatic mstate_t m_next(mstate_t s, logic en, logic rst,
                                     int unsigned cdiv, int unsigned ht, int unsigned vt);
    mstate_t n = s;
    if (rst) begin
      n = '{default: 0};
    end else if (en) begin
      n.div = (s.div + 1) % cdiv;
      if (s.div == cdiv - 1) begin
        n.h = (s.h + 1) % ht;
        if (s.h == ht - 1) begin
          n.v = (s.v + 1) % vt;
          if (s.v == vt - 1) n.fc = FC_EN ? (s.fc + 1) % 256 : 0;
        end
      end
    end
    return n;
  endfunction

  function automatic mout_t m_out(mstate_t s, logic en, logic rst,
                                  int unsigned cdiv, int unsigned hv, int unsigned vv);
    mout_t   o;
    mstate_t z = s;
    if (rst) z = '{default: 0};
    o.tick = en && (z.div == cdiv - 1);
    o.h    = z.h;
    o.v    = z.v;
    o.de   = (z.h < hv) && (z.v < vv);
    o.x    = o.de ? z.h : 0;
    o.y    = o.de ? z.v : 0;
    o.ls   = o.tick && (z.h == 0);
    o.fs   = o.ls && (z.v == 0);
    o.fc   = z.fc;
    return o;
  endfunction

  task automatic sb_cmp(input string p, input mout_t e, input logic tick,
                        input logic [9:0] h, input logic [9:0] v, input logic de,
                        input logic [9:0] x, input logic [9:0] y, input logic ls,
                        input logic fs, input logic [7:0] fc);
    check({p, "_tick"}, tick, e.tick);
    check({p, "_h"},    h,    e.h);
    check({p, "_v"},    v,    e.v);
    check({p, "_de"},   de,   e.de);
    check({p, "_x"},    x,    e.x);
    check({p, "_y"},    y,    e.y);
    check({p, "_ls"},   ls,   e.ls);
    check({p, "_fs"},   fs,   e.fs);
    check({p, "_fc"},   fc,   e.fc);
  endtask

  mstate_t sa = '{default: 0};
  mstate_t sb = '{default: 0};
  mout_t   qa[$];
  mout_t   qb[$];

  // Model advances on the edge with pre-edge inputs; expectations are queued after stimulus settles.
  always @(posedge clk) begin
    sa = m_next(sa, a_en, a_rst, A_DIV, A_HT, A_VT);
    sb = m_next(sb, b_en, b_rst, B_DIV, B_HT, B_VT);
    #2;
    qa.push_back(m_out(sa, a_en, a_rst, A_DIV, A_HV, A_VV));
    qb.push_back(m_out(sb, b_en, b_rst, B_DIV, B_HV, B_VV));
  end

  always @(negedge clk) begin
    mout_t e;
    if (qa.size() != 0) begin
      e = qa.pop_front();
      sb_cmp("sb_a", e, a_tick, a_h, a_v, a_de, a_x, a_y, a_ls, a_fs, a_fc);
    end
    if (qb.size() != 0) begin
      e = qb.pop_front();
      sb_cmp("sb_b", e, b_tick, b_h, b_v, b_de, b_x, b_y, b_ls, b_fs, b_fc);
    end
  end

  task automatic run_a();
    int k;
    a_rst = 1'b1;
    a_en  = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("a_rst_h", a_h, 0);
    check("a_rst_v", a_v, 0);
    check("a_rst_tick", a_tick, 0);
    check("a_rst_de", a_de, 1);
    check("a_rst_fs", a_fs, 0);
    check("a_rst_fc", a_fc, 0);
    @(posedge clk);
    #1 a_rst = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      check("a_first_tick", a_tick, c == 4);
      if (c == 4) begin
        check("a_first_fs", a_fs, 1);
        check("a_first_ls", a_ls, 1);
      end
      if (c == 5) check("a_h_after_first", a_h, 1);
    end
    k = 0;
    do begin @(negedge clk); k++; end while (!(a_tick && a_h == 10'd799) && k < 4000);
    check("a_reach_799", a_tick && a_h == 10'd799, 1);
    check("a_v_before_wrap", a_v, 0);
    @(negedge clk);
    check("a_wrap_h", a_h, 0);
    check("a_wrap_v", a_v, 1);
    k = 0;
    do begin @(negedge clk); k++; end while (!a_ls && k < 10);
    check("a_ls_seen", a_ls, 1);
    k = 0;
    do begin @(negedge clk); k++; end while (!a_ls && k < 4000);
    check("a_line_period", k, 3200);
    k = 0;
    do begin @(negedge clk); k++; end while (!(a_tick && a_h == 10'd99) && k < 4000);
    check("a_reach_99", a_tick && a_h == 10'd99, 1);
    repeat (3) @(posedge clk);
    #1 a_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("a_pause_tick", a_tick, 0);
      check("a_pause_h", a_h, 100);
      check("a_pause_ls", a_ls, 0);
    end
    @(posedge clk);
    #1 a_en = 1'b1;
    @(negedge clk);
    check("a_resume_tick0", a_tick, 0);
    @(negedge clk);
    check("a_resume_tick1", a_tick, 1);
    check("a_resume_h100", a_h, 100);
    @(negedge clk);
    check("a_resume_h101", a_h, 101);
  endtask

  task automatic run_b();
    int k;
    b_rst = 1'b1;
    b_en  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    b_rst = 1'b0;
    b_en  = 1'b1;
    @(negedge clk);
    check("b_first_tick", b_tick, 1);
    check("b_first_fs", b_fs, 1);
    check("b_first_ls", b_ls, 1);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      check("b_tick_every", b_tick, 1);
    end
    k = 0;
    do begin @(negedge clk); k++; end while (!(b_h == 10'd19 && b_v == 10'd7) && k < 400);
    check("b_reach_end", b_h == 10'd19 && b_v == 10'd7, 1);
    @(negedge clk);
    check("b_wrap_h", b_h, 0);
    check("b_wrap_v", b_v, 0);
    check("b_wrap_fs", b_fs, 1);
    check("b_wrap_fc", b_fc, FC_EN ? 1 : 0);
    k = 0;
    do begin @(negedge clk); k++; end while (!b_fs && k < 400);
    check("b_frame_period", k, 160);
    k = 0;
    do begin @(negedge clk); k++; end while (!(b_h == 10'd15 && b_v == 10'd5) && k < 400);
    check("b_last_vis_de", b_de, 1);
    check("b_last_vis_x", b_x, 15);
    check("b_last_vis_y", b_y, 5);
    @(negedge clk);
    check("b_h16_h", b_h, 16);
    check("b_h16_de", b_de, 0);
    check("b_h16_x", b_x, 0);
    check("b_h16_y", b_y, 0);
    k = 0;
    do begin @(negedge clk); k++; end while (!(b_h == 10'd0 && b_v == 10'd6) && k < 100);
    check("b_v6_reached", b_h == 10'd0 && b_v == 10'd6, 1);
    check("b_v6_de", b_de, 0);
    check("b_v6_y", b_y, 0);
    k = 0;
    do begin @(negedge clk); k++; end while (!(b_h == 10'd10 && b_v == 10'd4) && k < 400);
    check("b_mid_reached", b_h == 10'd10 && b_v == 10'd4, 1);
    #1 b_rst = 1'b1;
    #1;
    check("b_async_h", b_h, 0);
    check("b_async_v", b_v, 0);
    check("b_async_fc", b_fc, 0);
    check("b_async_de", b_de, 1);
    @(posedge clk);
    #1 b_rst = 1'b0;
    @(negedge clk);
    check("b_post_rst_fs", b_fs, 1);
    // Wrap count restarts from the reset; roll-over happens on the 256th wrap.
    for (int n = 1; n <= 256; n++) begin
      k = 0;
      do begin @(negedge clk); k++; end while (!b_fs && k < 200);
      check("b_fc_frame_len", k, 160);
      if (n == 255) check("b_fc_255", b_fc, FC_EN ? 255 : 0);
      if (n == 256) check("b_fc_roll", b_fc, 0);
    end
  endtask

  initial begin
    fork
      run_a();
      run_b();
    join
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
